// File: rtl/smiley_motion_ctrl.sv
// Game sequencer for the smiley mover: start/pause/hit-freeze/game-over control.
// Optional lives counting and game-over enabled by defining SMILEY_CTRL_LIVES_EN.
module smiley_motion_ctrl #(
  parameter int HIT_FREEZE_FRAMES    = 15,
  parameter int JUMP_COOLDOWN_FRAMES = 8,
  parameter int LIVES                = 3,
  parameter bit INITIAL_DIR          = 1'b1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       pauseKey,
  input  logic       leftKey,
  input  logic       rightKey,
  input  logic       jumpKey,
  input  logic       collision,
  output logic       X_direction,
  output logic       toggleY,
  output logic       respawn,
  output logic       moveFrame,
  output logic [2:0] state,
  output logic [3:0] livesLeft
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_HIT   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [7:0] FREEZE_INIT = 8'(HIT_FREEZE_FRAMES);
  localparam logic [7:0] CD_INIT     = 8'(JUMP_COOLDOWN_FRAMES);
  localparam logic [3:0] LIVES_INIT  = 4'(LIVES);

  state_t     r_state, w_state_nx;
  logic       r_xdir, w_xdir_nx;
  logic       r_tgl, w_tgl_nx;
  logic       r_rsp, w_rsp_nx;
  logic [7:0] r_freeze, w_freeze_nx;
  logic [7:0] r_cd, w_cd_nx;
  logic [3:0] r_lives, w_lives_nx;

  logic r_start_d, r_pause_d, r_jump_d, r_coll_d;
  logic w_start_re, w_pause_re, w_jump_re, w_coll_re;

  assign w_start_re = startKey  & ~r_start_d;
  assign w_pause_re = pauseKey  & ~r_pause_d;
  assign w_jump_re  = jumpKey   & ~r_jump_d;
  assign w_coll_re  = collision & ~r_coll_d;

  // Delay regs come out of reset high so held keys give no edge.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state   <= S_IDLE;
      r_xdir    <= INITIAL_DIR;
      r_tgl     <= 1'b0;
      r_rsp     <= 1'b0;
      r_freeze  <= 8'd0;
      r_cd      <= 8'd0;
      r_lives   <= LIVES_INIT;
      r_start_d <= 1'b1;
      r_pause_d <= 1'b1;
      r_jump_d  <= 1'b1;
      r_coll_d  <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_xdir    <= w_xdir_nx;
      r_tgl     <= w_tgl_nx;
      r_rsp     <= w_rsp_nx;
      r_freeze  <= w_freeze_nx;
      r_cd      <= w_cd_nx;
      r_lives   <= w_lives_nx;
      r_start_d <= startKey;
      r_pause_d <= pauseKey;
      r_jump_d  <= jumpKey;
      r_coll_d  <= collision;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_xdir_nx   = r_xdir;
    w_tgl_nx    = 1'b0;
    w_rsp_nx    = 1'b0;
    w_freeze_nx = r_freeze;
    w_cd_nx     = r_cd;
    w_lives_nx  = r_lives;
    case (r_state)
      S_IDLE: begin
        if (w_start_re) begin
          w_state_nx = S_RUN;
          w_rsp_nx   = 1'b1;
          w_xdir_nx  = INITIAL_DIR;
          w_cd_nx    = 8'd0;
        end
      end
      S_RUN: begin
        // Collision outranks pause, jump and steering.
        if (w_coll_re) begin
          w_state_nx  = S_HIT;
          w_freeze_nx = FREEZE_INIT;
`ifdef SMILEY_CTRL_LIVES_EN
          if (r_lives != 4'd0)
            w_lives_nx = r_lives - 4'd1;
`endif
        end else begin
          if (leftKey && !rightKey)
            w_xdir_nx = 1'b0;
          else if (rightKey && !leftKey)
            w_xdir_nx = 1'b1;
          if (w_pause_re)
            w_state_nx = S_PAUSE;
          if (w_jump_re && !w_pause_re && r_cd == 8'd0) begin
            w_tgl_nx = 1'b1;
            w_cd_nx  = CD_INIT;
          end else if (startOfFrame && r_cd != 8'd0) begin
            w_cd_nx = r_cd - 8'd1;
          end
        end
      end
      S_PAUSE: begin
        if (w_pause_re)
          w_state_nx = S_RUN;
      end
      S_HIT: begin
        if (r_freeze == 8'd0) begin
          w_cd_nx    = 8'd0;
          w_state_nx = S_RUN;
          w_rsp_nx   = 1'b1;
          w_xdir_nx  = INITIAL_DIR;
`ifdef SMILEY_CTRL_LIVES_EN
          if (r_lives == 4'd0) begin
            w_state_nx = S_OVER;
            w_rsp_nx   = 1'b0;
            w_xdir_nx  = r_xdir;
          end
`endif
        end else if (startOfFrame) begin
          w_freeze_nx = r_freeze - 8'd1;
        end
      end
      S_OVER: begin
        if (w_start_re) begin
          w_state_nx = S_IDLE;
          w_lives_nx = LIVES_INIT;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign moveFrame   = startOfFrame & (r_state == S_RUN);
  assign state       = r_state;
  assign X_direction = r_xdir;
  assign toggleY     = r_tgl;
  assign respawn     = r_rsp;
  assign livesLeft   = r_lives;

endmodule

// File: tb/tb_smiley_motion_ctrl.sv
// Bench for smiley_motion_ctrl: vector table plus scoreboard-checked sequences.
// Expectations adapt to whether SMILEY_CTRL_LIVES_EN is defined.
module tb_smiley_motion_ctrl;

  localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, PAUSE = 3'd2;
  localparam logic [2:0] HIT = 3'd3, OVER = 3'd4;
  localparam logic [3:0] NLIVES = 4'd3;
  localparam logic B0 = 1'b0, B1 = 1'b1;
`ifdef SMILEY_CTRL_LIVES_EN
  localparam bit LEN = 1'b1;
`else
  localparam bit LEN = 1'b0;
`endif

  typedef struct {
    logic sof, start, pause, left, right, jump, coll;
    logic [2:0] st;
    logic xd, ty, rs, mf;
    logic [3:0] lv;
  } vec_t;

  logic clk = 1'b0;
  logic resetN, startOfFrame, startKey, pauseKey;
  logic leftKey, rightKey, jumpKey, collision;
  logic X_direction, toggleY, respawn, moveFrame;
  logic [2:0] state;
  logic [3:0] livesLeft;

  int checks = 0;
  int failures = 0;
  vec_t sb[$];
  vec_t t1[8];
  logic [3:0] lv;
  logic cur_xd;

  always #5 clk = ~clk;

  smiley_motion_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .startKey(startKey), .pauseKey(pauseKey), .leftKey(leftKey),
    .rightKey(rightKey), .jumpKey(jumpKey), .collision(collision),
    .X_direction(X_direction), .toggleY(toggleY), .respawn(respawn),
    .moveFrame(moveFrame), .state(state), .livesLeft(livesLeft)
  );

  function automatic vec_t mk(
    input logic sof, sk, pk, lk, rk, jk, ck,
    input logic [2:0] es, input logic exd, ety, ers, emf,
    input logic [3:0] elv);
    vec_t v;
    v.sof = sof; v.start = sk; v.pause = pk; v.left = lk;
    v.right = rk; v.jump = jk; v.coll = ck;
    v.st = es; v.xd = exd; v.ty = ety; v.rs = ers; v.mf = emf;
    v.lv = elv;
    return v;
  endfunction

  function automatic logic [3:0] dec(input logic [3:0] l);
    if (LEN)
      return (l == 4'd0) ? 4'd0 : l - 4'd1;
    return NLIVES;
  endfunction

  task automatic chk(input string nm, input string fld,
                     input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%0h exp=%0h", nm, fld, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    vec_t e;
    startOfFrame = v.sof; startKey = v.start; pauseKey = v.pause;
    leftKey = v.left; rightKey = v.right; jumpKey = v.jump;
    collision = v.coll;
    sb.push_back(v);
    #2;
    chk(nm, "moveFrame", {3'd0, moveFrame}, {3'd0, v.mf});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(nm, "state", {1'b0, state}, {1'b0, e.st});
    chk(nm, "xdir", {3'd0, X_direction}, {3'd0, e.xd});
    chk(nm, "toggleY", {3'd0, toggleY}, {3'd0, e.ty});
    chk(nm, "respawn", {3'd0, respawn}, {3'd0, e.rs});
    chk(nm, "lives", livesLeft, e.lv);
  endtask

  task automatic run_j(input logic sof, input logic jk, input logic ety);
    apply(mk(sof, B0, B0, B0, B0, jk, B0, RUN, B1, ety, B0, sof, lv), "jump");
  endtask

  // Enters HIT from RUN with a simultaneous jump rise, then rides out the freeze.
  task automatic do_hit(input string nm);
    logic [2:0] ex;
    apply(mk(B0, B0, B0, B1, B0, B0, B0, RUN, B0, B0, B0, B0, lv), nm);
    lv = dec(lv);
    apply(mk(B0, B0, B0, B0, B0, B1, B1, HIT, B0, B0, B0, B0, lv), nm);
    ex = (lv == 4'd0) ? OVER : RUN;
    for (int i = 0; i < 15; i++) begin
      apply(mk(B1, B0, B0, B0, B0, B0, B1, HIT, B0, B0, B0, B0, lv), nm);
      if (i == 14)
        apply(mk(B0, B0, B0, B0, B0, B0, B1, ex, ex == RUN, B0,
                 ex == RUN, B0, lv), nm);
      else
        apply(mk(B0, B0, B0, B0, B0, B0, B1, HIT, B0, B0, B0, B0, lv), nm);
    end
    cur_xd = (ex == RUN);
    apply(mk(B1, B0, B0, B0, B0, B0, B1, ex, cur_xd, B0, B0,
             ex == RUN, lv), nm);
    apply(mk(B0, B0, B0, B0, B0, B0, B0, ex, cur_xd, B0, B0, B0, lv), nm);
  endtask

  initial begin
    logic over;
    resetN = 1'b0;
    startOfFrame = 0; startKey = 0; pauseKey = 0; leftKey = 0;
    rightKey = 0; jumpKey = 0; collision = 0;
    lv = NLIVES;
    cur_xd = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(B0, B0, B0, B0, B0, B0, B0, IDLE, B1, B0, B0, B0, NLIVES), "reset");
    resetN = 1'b1;

    t1[0] = mk(B0, B0, B0, B0, B0, B0, B0, IDLE, B1, B0, B0, B0, NLIVES);
    t1[1] = mk(B0, B1, B0, B0, B0, B0, B0, RUN,  B1, B0, B1, B0, NLIVES);
    t1[2] = mk(B1, B1, B0, B0, B0, B0, B0, RUN,  B1, B0, B0, B1, NLIVES);
    t1[3] = mk(B0, B0, B0, B0, B1, B0, B0, RUN,  B1, B0, B0, B0, NLIVES);
    t1[4] = mk(B0, B0, B0, B1, B0, B0, B0, RUN,  B0, B0, B0, B0, NLIVES);
    t1[5] = mk(B0, B0, B0, B1, B1, B0, B0, RUN,  B0, B0, B0, B0, NLIVES);
    t1[6] = mk(B1, B0, B0, B0, B0, B0, B0, RUN,  B0, B0, B0, B1, NLIVES);
    t1[7] = mk(B0, B0, B0, B0, B1, B0, B0, RUN,  B1, B0, B0, B0, NLIVES);
    for (int i = 0; i < 8; i++)
      apply(t1[i], $sformatf("start_dir%0d", i));

    run_j(B0, B1, B1); run_j(B0, B0, B0);
    repeat (3) begin run_j(B1, B0, B0); run_j(B0, B0, B0); end
    run_j(B0, B1, B0); run_j(B0, B0, B0);
    repeat (4) begin run_j(B1, B0, B0); run_j(B0, B0, B0); end
    run_j(B0, B1, B0); run_j(B0, B0, B0);
    run_j(B1, B0, B0); run_j(B0, B0, B0);
    run_j(B0, B1, B1); run_j(B0, B1, B0); run_j(B0, B0, B0);
    repeat (8) begin run_j(B1, B0, B0); run_j(B0, B0, B0); end

    do_hit("hit1");
    do_hit("hit2");
    do_hit("hit3");

    over = (state == OVER) && LEN;
    apply(mk(B0, B1, B0, B0, B0, B0, B0, over ? IDLE : RUN, cur_xd,
             B0, B0, B0, NLIVES), "over_start");
    apply(mk(B0, B0, B0, B0, B0, B0, B0, over ? IDLE : RUN, cur_xd,
             B0, B0, B0, NLIVES), "over_start");
    apply(mk(B0, B1, B0, B0, B0, B0, B0, RUN, B1, B0, over, B0, NLIVES),
          "restart");
    apply(mk(B0, B0, B0, B0, B0, B0, B0, RUN, B1, B0, B0, B0, NLIVES),
          "restart");
    lv = NLIVES;
    cur_xd = 1'b1;

    apply(mk(B0, B0, B1, B0, B0, B0, B0, PAUSE, B1, B0, B0, B0, lv), "pause");
    for (int i = 0; i < 5; i++)
      apply(mk(B1, B0, B0, B1, B0, i[0], i[0], PAUSE, B1, B0, B0, B0, lv),
            "pause_hold");
    apply(mk(B1, B0, B1, B0, B0, B0, B0, RUN, B1, B0, B0, B0, lv), "resume");
    apply(mk(B1, B0, B0, B0, B0, B0, B0, RUN, B1, B0, B0, B1, lv), "resume");

    apply(mk(B0, B0, B0, B0, B0, B0, B0, RUN, B1, B0, B0, B0, lv), "rst_hit");
    lv = dec(lv);
    apply(mk(B0, B0, B0, B0, B0, B0, B1, HIT, B1, B0, B0, B0, lv), "rst_hit");
    resetN = 1'b0;
    apply(mk(B1, B1, B1, B0, B0, B1, B1, IDLE, B1, B0, B0, B0, NLIVES),
          "rst_mid");
    resetN = 1'b1;
    repeat (3)
      apply(mk(B1, B1, B1, B0, B0, B1, B1, IDLE, B1, B0, B0, B0, NLIVES),
            "rst_held");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
